// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 access codes, FSM states
// and the byte-enable helper.
// Contents: F3_* constants, state_t enum, lane_be() function.
package lsu_pkg;

    // funct3 access codes (instr[14:12])
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Byte enables from access size (funct3[1:0]) and byte offset.
    function automatic logic [3:0] lane_be(input logic [1:0] size, input logic [1:0] off);
        logic [3:0] be;
        case (size)
            2'b00:   be = 4'b0001 << off;
            2'b01:   be = off[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/lsu_load_extend.sv
// Load extraction: picks the addressed lane out of a bus word and sign- or
// zero-extends it according to funct3. Purely combinational.
// Ports: i_rdata (bus word), i_funct3 (size/sign), i_off (byte offset), o_data (result).
module load_extend
    import lsu_pkg::*;
(
    input  logic [31:0] i_rdata,
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_off,
    output logic [31:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = i_rdata[{i_off, 3'b000} +: 8];
        // Halves are only ever aligned, so addr[1] alone picks the lane.
        w_half = i_off[1] ? i_rdata[31:16] : i_rdata[15:0];
        case (i_funct3)
            F3_B:    o_data = {{24{w_byte[7]}}, w_byte};
            F3_H:    o_data = {{16{w_half[15]}}, w_half};
            F3_BU:   o_data = {24'd0, w_byte};
            F3_HU:   o_data = {16'd0, w_half};
            default: o_data = i_rdata;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// Load/store unit: runs one req/ack bus transaction per load/store, stalls the
// core meanwhile, returns the extended load result and flags access faults.
// Ports: core side (mem_read/mem_write/funct3/addr/write_data -> read_data/
// stall/access_fault), bus side (bus_req/we/addr/be/wdata -> bus_ack/rdata).
module lsu
    import lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        stall,
    output logic        access_fault,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
);

    state_t      r_state, w_next;
    logic [15:0] r_cnt;
    logic        r_fault;
    logic [2:0]  r_f3;
    logic [1:0]  r_off;
    logic [31:0] r_rdata;

    logic        w_access, w_legal, w_misalign, w_start, w_bad, w_timeout;
    logic [31:0] w_wdata, w_ext;

    assign w_access = mem_read | mem_write;

    // Unsigned codes only exist for loads; a simultaneous read+write is a write.
    always_comb begin
        case (funct3)
            F3_B, F3_H, F3_W: w_legal = 1'b1;
            F3_BU, F3_HU:     w_legal = ~mem_write;
            default:          w_legal = 1'b0;
        endcase
    end

    always_comb begin
        case (funct3[1:0])
            2'b01:   w_misalign = addr[0];
            2'b10:   w_misalign = (addr[1:0] != 2'b00);
            default: w_misalign = 1'b0;
        endcase
    end

    always_comb begin
        case (funct3[1:0])
            2'b00:   w_wdata = {4{write_data[7:0]}};
            2'b01:   w_wdata = {2{write_data[15:0]}};
            default: w_wdata = write_data;
        endcase
    end

    // Gated by reset so stall/fault drop the moment reset is asserted.
    assign w_start   = (r_state == IDLE) && !reset && w_access && w_legal && !w_misalign;
    assign w_bad     = (r_state == IDLE) && !reset && w_access && !(w_legal && !w_misalign);
    // Counter holds the number of completed BUS cycles, so this fires on cycle TIMEOUT.
    assign w_timeout = (r_cnt == 16'(TIMEOUT - 1));

    load_extend u_load_extend (
        .i_rdata  (r_rdata),
        .i_funct3 (r_f3),
        .i_off    (r_off),
        .o_data   (w_ext)
    );

    // FSM: state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    // FSM: next state
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_start) w_next = BUS;
            BUS:     if (bus_ack || w_timeout) w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        stall        = 1'b0;
        access_fault = 1'b0;
        read_data    = 32'd0;
        case (r_state)
            IDLE: begin
                stall        = w_start;
                access_fault = w_bad;
            end
            BUS:  stall = 1'b1;
            DONE: begin
                access_fault = r_fault;
                if (!r_fault && !bus_we) read_data = w_ext;
            end
            default: ;
        endcase
    end

    // Bus registers, counter and completion status
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= 32'd0;
            bus_be    <= 4'd0;
            bus_wdata <= 32'd0;
            r_cnt     <= 16'd0;
            r_fault   <= 1'b0;
            r_f3      <= 3'd0;
            r_off     <= 2'd0;
            r_rdata   <= 32'd0;
        end else begin
            case (r_state)
                IDLE: if (w_start) begin
                    bus_req   <= 1'b1;
                    bus_we    <= mem_write;
                    bus_addr  <= {addr[31:2], 2'b00};
                    bus_be    <= lane_be(funct3[1:0], addr[1:0]);
                    bus_wdata <= w_wdata;
                    r_f3      <= funct3;
                    r_off     <= addr[1:0];
                    r_cnt     <= 16'd0;
                    r_fault   <= 1'b0;
                end
                BUS: begin
                    // Ack has priority over a coincident timeout.
                    if (bus_ack) begin
                        bus_req <= 1'b0;
                        r_rdata <= bus_rdata;
                    end else if (w_timeout) begin
                        bus_req <= 1'b0;
                        r_fault <= 1'b1;
                    end else if (r_cnt != 16'hFFFF) begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
